wb_stage: RTL and testbench

Write-back stage of the five-stage MIPS pipeline. It holds the instruction leaving MEM in a one-entry pipeline register and commits its GPR write. It drives the CP0 register file's commit interface (mtc0/mfc0/eret/exception) and injects pending interrupts onto the committing instruction. It also generates the single-cycle pipeline flush and redirect PC for exceptions and eret.

---
 rtl/wb_stage_pkg.sv | 36 +++
 rtl/wb_ex_sel.sv | 40 ++++
 rtl/wb_stage.sv | 149 ++++++++++++++
 tb/tb_wb_stage.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage.
//   EX_*             exception codes reported to CP0 Cause.ExcCode
//   CR_*             CP0 register addresses as {sel[2:0], rd[4:0]}
//   EX_ENTRY_DEFAULT exception vector used while Status.BEV = 1
//   ws_payload_t     contents of the MEM->WB pipeline register
package wb_stage_pkg;

  localparam logic [4:0] EX_INT  = 5'h00;
  localparam logic [4:0] EX_ADEL = 5'h04;
  localparam logic [4:0] EX_SYS  = 5'h08;

  localparam logic [7:0] CR_BADVADDR = 8'h08;
  localparam logic [7:0] CR_COUNT    = 8'h09;
  localparam logic [7:0] CR_COMPARE  = 8'h0B;
  localparam logic [7:0] CR_STATUS   = 8'h0C;
  localparam logic [7:0] CR_CAUSE    = 8'h0D;
  localparam logic [7:0] CR_EPC      = 8'h0E;

  localparam logic [31:0] EX_ENTRY_DEFAULT = 32'hBFC0_0380;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result;     // ALU/load result; rt value for mtc0
    logic [31:0] badvaddr;
    logic [4:0]  dest;
    logic        gr_we;
    logic        op_mtc0;
    logic        op_mfc0;
    logic        op_eret;
    logic        bd;
    logic [7:0]  c0_addr;    // {sel, rd}
    logic        ex;
    logic [4:0]  excode;
  } ws_payload_t;

endpackage

// File: rtl/wb_ex_sel.sv
// Exception selection for the committing instruction.
// Inputs : ws_valid, stored upstream exception flag/code, CP0 interrupt
//          request and the stored CP0 op bits.
// Outputs: ex (commit is an exception), wb_excode, and op_mtc0/op_mfc0/
//          op_eret gated so they only fire on a valid, non-excepting
//          instruction.
module wb_ex_sel
  import wb_stage_pkg::*;
(
  input  logic       ws_valid,
  input  logic       ms_ex_r,
  input  logic [4:0] ms_excode_r,
  input  logic       c0_int_req,
  input  logic       op_mtc0_r,
  input  logic       op_mfc0_r,
  input  logic       op_eret_r,
  output logic       ex,
  output logic [4:0] wb_excode,
  output logic       op_mtc0,
  output logic       op_mfc0,
  output logic       op_eret
);

  logic int_take;
  logic commit_ok;

  // An interrupt is attached to whatever valid instruction is committing;
  // it outranks any exception that instruction already carries.
  assign int_take  = ws_valid && c0_int_req;
  assign ex        = ws_valid && (ms_ex_r || int_take);
  assign wb_excode = int_take ? EX_INT : ms_excode_r;

  // CP0 side effects only for a real instruction that is not being
  // replaced by an exception; stale op bits in a bubble stay silent.
  assign commit_ok = ws_valid && !ex;
  assign op_mtc0   = op_mtc0_r && commit_ok;
  assign op_mfc0   = op_mfc0_r && commit_ok;
  assign op_eret   = op_eret_r && commit_ok;

endmodule

// File: rtl/wb_stage.sv
// MIPS write-back stage.
// Holds the instruction leaving MEM in a one-entry register and commits it:
//   - GPR write port (rf_*), bypass tag/data (ws_fwd_*)
//   - CP0 commit interface (wb_valid, op_*, wb_ex, wb_excode, wb_rd,
//     wb_sel, c0_wdata, wb_pc, wb_bd, wb_badvaddr); c0_rdata returns the
//     mfc0 read data or EPC during eret
//   - one-cycle flush + redirect PC for exceptions and eret
//   - debug trace port (debug_wb_*)
// Handshake: ms_to_ws_valid / ws_allowin.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter logic [31:0] EX_ENTRY = EX_ENTRY_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ms_to_ws_valid,
  output logic        ws_allowin,
  input  logic [31:0] ms_pc,
  input  logic [31:0] ms_result,
  input  logic [31:0] ms_badvaddr,
  input  logic [4:0]  ms_dest,
  input  logic        ms_gr_we,
  input  logic        ms_op_mtc0,
  input  logic        ms_op_mfc0,
  input  logic        ms_op_eret,
  input  logic        ms_bd,
  input  logic [7:0]  ms_c0_addr,
  input  logic        ms_ex,
  input  logic [4:0]  ms_excode,
  input  logic        c0_int_req,
  input  logic [31:0] c0_rdata,
  output logic        wb_valid,
  output logic        op_mtc0,
  output logic        op_mfc0,
  output logic        op_eret,
  output logic        wb_ex,
  output logic        wb_bd,
  output logic [4:0]  wb_rd,
  output logic [2:0]  wb_sel,
  output logic [4:0]  wb_excode,
  output logic [31:0] c0_wdata,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_badvaddr,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [4:0]  ws_fwd_dest,
  output logic [31:0] ws_fwd_data,
  output logic        ws_flush,
  output logic [31:0] ws_flush_pc,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  logic        ws_valid;
  logic        ws_ready_go;
  logic        ex;
  ws_payload_t ws_r;
  ws_payload_t ms_payload;

  // WB never stalls; allowin is kept in its general form so a stall
  // source can be added later without touching the handshake.
  assign ws_ready_go = 1'b1;
  assign ws_allowin  = !ws_valid || ws_ready_go;

  always_comb begin
    ms_payload          = '0;
    ms_payload.pc       = ms_pc;
    ms_payload.result   = ms_result;
    ms_payload.badvaddr = ms_badvaddr;
    ms_payload.dest     = ms_dest;
    ms_payload.gr_we    = ms_gr_we;
    ms_payload.op_mtc0  = ms_op_mtc0;
    ms_payload.op_mfc0  = ms_op_mfc0;
    ms_payload.op_eret  = ms_op_eret;
    ms_payload.bd       = ms_bd;
    ms_payload.c0_addr  = ms_c0_addr;
    ms_payload.ex       = ms_ex;
    ms_payload.excode   = ms_excode;
  end

  // A flush kills both the committing instruction and whatever MEM offers
  // in the same cycle, so ws_flush lasts exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ws_valid <= 1'b0;
    end else if (ws_flush) begin
      ws_valid <= 1'b0;
    end else if (ws_allowin) begin
      ws_valid <= ms_to_ws_valid;
    end
  end

  // Payload may load during a flush cycle; ws_valid is cleared then, so
  // the captured values are never committed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ws_r <= '0;
    end else if (ms_to_ws_valid && ws_allowin) begin
      ws_r <= ms_payload;
    end
  end

  wb_ex_sel u_ex_sel (
    .ws_valid    (ws_valid),
    .ms_ex_r     (ws_r.ex),
    .ms_excode_r (ws_r.excode),
    .c0_int_req  (c0_int_req),
    .op_mtc0_r   (ws_r.op_mtc0),
    .op_mfc0_r   (ws_r.op_mfc0),
    .op_eret_r   (ws_r.op_eret),
    .ex          (ex),
    .wb_excode   (wb_excode),
    .op_mtc0     (op_mtc0),
    .op_mfc0     (op_mfc0),
    .op_eret     (op_eret)
  );

  // CP0 commit interface
  assign wb_valid    = ws_valid;
  assign wb_ex       = ex;
  assign wb_rd       = ws_r.c0_addr[4:0];
  assign wb_sel      = ws_r.c0_addr[7:5];
  assign c0_wdata    = ws_r.result;
  assign wb_pc       = ws_r.pc;
  assign wb_bd       = ws_r.bd;
  assign wb_badvaddr = ws_r.badvaddr;

  // GPR write and bypass
  assign rf_we       = ws_valid && ws_r.gr_we && !ex;
  assign rf_waddr    = ws_r.dest;
  assign rf_wdata    = op_mfc0 ? c0_rdata : ws_r.result;
  assign ws_fwd_dest = rf_we ? ws_r.dest : 5'd0;
  assign ws_fwd_data = rf_wdata;

  // Redirect: exception vector, or EPC (presented on c0_rdata) for eret
  assign ws_flush    = ex || op_eret;
  assign ws_flush_pc = ex ? EX_ENTRY : c0_rdata;

  // Debug trace
  assign debug_wb_pc       = ws_r.pc;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = ws_r.dest;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
`timescale 1ns/100ps
module tb_wb_stage;

  localparam logic [31:0] EXV = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ms_to_ws_valid = 1'b0;
  logic        ws_allowin;
  logic [31:0] ms_pc = '0, ms_result = '0, ms_badvaddr = '0;
  logic [4:0]  ms_dest = '0;
  logic        ms_gr_we = 1'b0, ms_op_mtc0 = 1'b0, ms_op_mfc0 = 1'b0, ms_op_eret = 1'b0, ms_bd = 1'b0;
  logic [7:0]  ms_c0_addr = '0;
  logic        ms_ex = 1'b0;
  logic [4:0]  ms_excode = '0;
  logic        c0_int_req = 1'b0;
  logic [31:0] c0_rdata = '0;
  logic        wb_valid, op_mtc0, op_mfc0, op_eret, wb_ex, wb_bd;
  logic [4:0]  wb_rd, wb_excode;
  logic [2:0]  wb_sel;
  logic [31:0] c0_wdata, wb_pc, wb_badvaddr;
  logic        rf_we;
  logic [4:0]  rf_waddr, ws_fwd_dest;
  logic [31:0] rf_wdata, ws_fwd_data;
  logic        ws_flush;
  logic [31:0] ws_flush_pc;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  int n_checks = 0;
  int n_fail = 0;
  bit pending_flush = 1'b0;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        ex;
    logic [4:0]  excode;
    logic        mtc0, mfc0, eret;
    logic        flush;
    logic [31:0] flush_pc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_result(ms_result), .ms_badvaddr(ms_badvaddr),
    .ms_dest(ms_dest), .ms_gr_we(ms_gr_we),
    .ms_op_mtc0(ms_op_mtc0), .ms_op_mfc0(ms_op_mfc0), .ms_op_eret(ms_op_eret), .ms_bd(ms_bd),
    .ms_c0_addr(ms_c0_addr), .ms_ex(ms_ex), .ms_excode(ms_excode),
    .c0_int_req(c0_int_req), .c0_rdata(c0_rdata),
    .wb_valid(wb_valid), .op_mtc0(op_mtc0), .op_mfc0(op_mfc0), .op_eret(op_eret),
    .wb_ex(wb_ex), .wb_bd(wb_bd), .wb_rd(wb_rd), .wb_sel(wb_sel), .wb_excode(wb_excode),
    .c0_wdata(c0_wdata), .wb_pc(wb_pc), .wb_badvaddr(wb_badvaddr),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .ws_fwd_dest(ws_fwd_dest), .ws_fwd_data(ws_fwd_data),
    .ws_flush(ws_flush), .ws_flush_pc(ws_flush_pc),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  // Offer one instruction from MEM, push its expected commit, then after the
  // capturing edge present the CP0 inputs and compare the commit cycle.
  task automatic send(input string name, input logic [31:0] pc, input logic [4:0] dest,
                      input logic [31:0] result, input logic gr_we,
                      input logic mtc0, input logic mfc0, input logic eret,
                      input logic exc, input logic [4:0] excode, input logic [7:0] c0a,
                      input logic [31:0] c0_rd, input logic int_req);
    exp_t e;
    exp_t g;
    if (pending_flush) begin
      @(posedge clk); #2;
      pending_flush = 1'b0;
    end
    ms_pc = pc; ms_dest = dest; ms_result = result; ms_gr_we = gr_we;
    ms_op_mtc0 = mtc0; ms_op_mfc0 = mfc0; ms_op_eret = eret;
    ms_ex = exc; ms_excode = excode; ms_c0_addr = c0a;
    ms_to_ws_valid = 1'b1;
    e.name     = name;
    e.pc       = pc;
    e.ex       = exc || int_req;
    e.excode   = int_req ? 5'd0 : excode;
    e.rf_we    = gr_we && !e.ex;
    e.waddr    = dest;
    e.mtc0     = mtc0 && !e.ex;
    e.mfc0     = mfc0 && !e.ex;
    e.eret     = eret && !e.ex;
    e.wdata    = e.mfc0 ? c0_rd : result;
    e.flush    = e.ex || e.eret;
    e.flush_pc = e.ex ? EXV : c0_rd;
    sb.push_back(e);
    @(posedge clk); #1;
    ms_to_ws_valid = 1'b0;
    c0_rdata = c0_rd; c0_int_req = int_req;
    #1;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++; $display("FAIL %s scoreboard: got empty queue required one entry", name);
    end else begin
      g = sb.pop_front();
      n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL %s wb_valid: got %b required 1", g.name, wb_valid); end
      n_checks++; if (debug_wb_pc !== g.pc) begin n_fail++; $display("FAIL %s debug_wb_pc: got %h required %h", g.name, debug_wb_pc, g.pc); end
      n_checks++; if (rf_we !== g.rf_we) begin n_fail++; $display("FAIL %s rf_we: got %b required %b", g.name, rf_we, g.rf_we); end
      n_checks++; if (debug_wb_rf_wen !== {4{g.rf_we}}) begin n_fail++; $display("FAIL %s debug_wen: got %h required %h", g.name, debug_wb_rf_wen, {4{g.rf_we}}); end
      n_checks++; if (ws_fwd_dest !== (g.rf_we ? g.waddr : 5'd0)) begin n_fail++; $display("FAIL %s fwd_dest: got %0d required %0d", g.name, ws_fwd_dest, g.rf_we ? g.waddr : 5'd0); end
      if (g.rf_we) begin
        n_checks++; if (rf_waddr !== g.waddr) begin n_fail++; $display("FAIL %s rf_waddr: got %0d required %0d", g.name, rf_waddr, g.waddr); end
        n_checks++; if (rf_wdata !== g.wdata) begin n_fail++; $display("FAIL %s rf_wdata: got %h required %h", g.name, rf_wdata, g.wdata); end
        n_checks++; if (ws_fwd_data !== g.wdata) begin n_fail++; $display("FAIL %s fwd_data: got %h required %h", g.name, ws_fwd_data, g.wdata); end
      end
      n_checks++; if (wb_ex !== g.ex) begin n_fail++; $display("FAIL %s wb_ex: got %b required %b", g.name, wb_ex, g.ex); end
      if (g.ex) begin
        n_checks++; if (wb_excode !== g.excode) begin n_fail++; $display("FAIL %s wb_excode: got %0d required %0d", g.name, wb_excode, g.excode); end
      end
      n_checks++; if ({op_mtc0, op_mfc0, op_eret} !== {g.mtc0, g.mfc0, g.eret}) begin n_fail++; $display("FAIL %s op_mtc0/mfc0/eret: got %b%b%b required %b%b%b", g.name, op_mtc0, op_mfc0, op_eret, g.mtc0, g.mfc0, g.eret); end
      n_checks++; if (ws_flush !== g.flush) begin n_fail++; $display("FAIL %s ws_flush: got %b required %b", g.name, ws_flush, g.flush); end
      if (g.flush) begin
        n_checks++; if (ws_flush_pc !== g.flush_pc) begin n_fail++; $display("FAIL %s flush_pc: got %h required %h", g.name, ws_flush_pc, g.flush_pc); end
      end
      pending_flush = g.flush;
      $display("commit %s pc=%h rf_we=%b waddr=%0d wdata=%h ex=%b excode=%0d flush=%b fpc=%h",
               g.name, debug_wb_pc, rf_we, rf_waddr, rf_wdata, wb_ex, wb_excode, ws_flush, ws_flush_pc);
    end
  endtask

  task automatic test_reset;
    #2;
    n_checks++; if ({wb_valid, rf_we, ws_flush, wb_ex, op_mtc0, op_mfc0, op_eret} !== 7'b0) begin n_fail++; $display("FAIL reset ctrl: got %b required 0000000", {wb_valid, rf_we, ws_flush, wb_ex, op_mtc0, op_mfc0, op_eret}); end
    n_checks++; if (debug_wb_rf_wen !== 4'h0) begin n_fail++; $display("FAIL reset debug_wen: got %h required 0", debug_wb_rf_wen); end
    n_checks++; if (debug_wb_pc !== 32'h0) begin n_fail++; $display("FAIL reset debug_pc: got %h required 0", debug_wb_pc); end
    n_checks++; if (ws_fwd_dest !== 5'd0) begin n_fail++; $display("FAIL reset fwd_dest: got %0d required 0", ws_fwd_dest); end
    n_checks++; if (ws_allowin !== 1'b1) begin n_fail++; $display("FAIL reset allowin: got %b required 1", ws_allowin); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #2;
    $display("reset checked");
  endtask

  task automatic test_addu;
    send("addu", 32'hBFC0_0010, 5'd5, 32'h0000_1234, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 32'hDEAD_0000, 1'b0);
  endtask

  task automatic test_mfc0;
    send("mfc0_status", 32'hBFC0_0014, 5'd8, 32'h5555_AAAA, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 8'h0C, 32'h0040_0001, 1'b0);
    n_checks++; if ({wb_sel, wb_rd} !== 8'h0C) begin n_fail++; $display("FAIL mfc0 c0_addr: got %h required 0c", {wb_sel, wb_rd}); end
  endtask

  task automatic test_syscall;
    ms_badvaddr = 32'h1234_5678; ms_bd = 1'b1;
    send("syscall", 32'hBFC0_0020, 5'd9, 32'h0000_0077, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 8'h00, 32'h0, 1'b0);
    n_checks++; if ({wb_bd, wb_badvaddr} !== {1'b1, 32'h1234_5678}) begin n_fail++; $display("FAIL syscall bd/badvaddr: got %b/%h required 1/12345678", wb_bd, wb_badvaddr); end
    ms_bd = 1'b0; ms_badvaddr = '0;
    // offer during the flush cycle: must be discarded
    ms_pc = 32'hBFC0_0024; ms_dest = 5'd3; ms_result = 32'h99; ms_gr_we = 1'b1; ms_ex = 1'b0;
    ms_to_ws_valid = 1'b1;
    @(posedge clk); #1; ms_to_ws_valid = 1'b0; #1;
    pending_flush = 1'b0;
    n_checks++; if ({wb_valid, rf_we, ws_flush} !== 3'b000) begin n_fail++; $display("FAIL syscall drop: got valid/we/flush=%b required 000", {wb_valid, rf_we, ws_flush}); end
    $display("syscall follow-on offer dropped valid=%b", wb_valid);
  endtask

  task automatic test_eret;
    send("eret", 32'hBFC0_0030, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 8'h0E, 32'hBFC0_1000, 1'b0);
    @(posedge clk); #2;
    pending_flush = 1'b0;
    n_checks++; if ({op_eret, ws_flush, wb_valid} !== 3'b000) begin n_fail++; $display("FAIL eret stale: got eret/flush/valid=%b required 000", {op_eret, ws_flush, wb_valid}); end
    $display("eret bubble op_eret=%b", op_eret);
  endtask

  task automatic test_interrupt;
    c0_int_req = 1'b1; #1;
    n_checks++; if ({wb_ex, ws_flush} !== 2'b00) begin n_fail++; $display("FAIL int bubble: got ex/flush=%b required 00", {wb_ex, ws_flush}); end
    send("int_mtc0_compare", 32'hBFC0_0040, 5'd0, 32'h0000_0100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h0B, 32'h0, 1'b1);
    c0_int_req = 1'b0;
    send("int_on_syscall", 32'hBFC0_0044, 5'd2, 32'h3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 8'h00, 32'h0, 1'b1);
    c0_int_req = 1'b0;
    send("int_on_eret", 32'hBFC0_0048, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 8'h0E, 32'hBFC0_2000, 1'b1);
    c0_int_req = 1'b0;
  endtask

  task automatic test_back_to_back;
    realtime t0;
    if (pending_flush) begin @(posedge clk); #2; pending_flush = 1'b0; end
    t0 = $realtime;
    for (int i = 0; i < 4; i++) begin
      send($sformatf("b2b%0d", i), 32'hBFC0_0100 + 32'(i * 4), 5'(i + 10), $urandom, 1'b1,
           1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, $urandom, 1'b0);
    end
    n_checks++; if ($realtime - t0 != 40.0) begin n_fail++; $display("FAIL b2b throughput: got %0t ns required 40 ns", $realtime - t0); end
  endtask

  task automatic test_mid_reset;
    ms_pc = 32'hBFC0_0200; ms_dest = 5'd7; ms_result = 32'hCAFE; ms_gr_we = 1'b1;
    ms_op_mtc0 = 1'b0; ms_op_mfc0 = 1'b0; ms_op_eret = 1'b0; ms_ex = 1'b0;
    ms_to_ws_valid = 1'b1;
    @(posedge clk); #1; ms_to_ws_valid = 1'b0;
    n_checks++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL midrst pre: got rf_we=%b required 1", rf_we); end
    rst_n = 1'b0; #0.5;
    n_checks++; if ({wb_valid, rf_we, ws_flush} !== 3'b000) begin n_fail++; $display("FAIL midrst: got valid/we/flush=%b required 000", {wb_valid, rf_we, ws_flush}); end
    #0.5; rst_n = 1'b1;
    $display("mid reset valid=%b rf_we=%b", wb_valid, rf_we);
    #1;
    send("after_reset", 32'hBFC0_0204, 5'd6, 32'h0000_BEEF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 32'h0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_addu();
    test_mfc0();
    test_syscall();
    test_eret();
    test_interrupt();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion required finish before 100000 ns");
    $fatal(1, "timeout");
  end

endmodule
